// File: rtl/line_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem_pkg
//  Description : Shared types, default line geometry and the byte-strobe to
//                bit-mask helper for the line_mem_burst block.
//  Revision    : 1.0 - initial release
// ============================================================================
package line_mem_pkg;

  // Controller states. CLEAR is only entered when the power-up sweep is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Default geometry (4 words x 32 bits x 1024 lines) and its address fields.
  localparam int C_DEF_XLEN  = 32;
  localparam int C_DEF_WORDS = 4;
  localparam int C_DEF_DEPTH = 1024;
  localparam int C_BYTE_W    = $clog2(C_DEF_XLEN / 8);
  localparam int C_OFF_W     = $clog2(C_DEF_WORDS);
  localparam int C_IDX_W     = $clog2(C_DEF_DEPTH);

  // Widest word the mask helper supports; callers zero-extend and truncate.
  localparam int C_MAX_XLEN  = 512;
  localparam int C_MAX_STRB  = C_MAX_XLEN / 8;

  // Expand one enable bit per byte into a full bit mask.
  function automatic logic [C_MAX_XLEN-1:0] strobe_to_mask(input logic [C_MAX_STRB-1:0] strobe);
    logic [C_MAX_XLEN-1:0] m;
    m = '0;
    for (int b = 0; b < C_MAX_STRB; b++) begin
      m[b*8 +: 8] = {8{strobe[b]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_mem_burst_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem_burst_if
//  Description : Request/response handshake bundle between a requester
//                (master) and the line memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface line_mem_burst_if #(
  parameter int XLEN = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_burst;
  logic [31:0]       req_adr;
  logic [XLEN-1:0]   req_data;
  logic [XLEN/8-1:0] req_strobe;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_data;
  logic              resp_last;
  logic              resp_error;

  modport master (
    output req_valid, req_we, req_burst, req_adr, req_data, req_strobe, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_last, resp_error
  );

  modport slave (
    input  req_valid, req_we, req_burst, req_adr, req_data, req_strobe, resp_ready,
    output req_ready, resp_valid, resp_data, resp_last, resp_error
  );

endinterface
`default_nettype wire

// File: rtl/line_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem_array
//  Description : Line storage built from one bank per word position. Each bank
//                has a byte-enabled write port and a registered read port, so
//                every bank maps onto a plain inferable RAM. we_all writes the
//                same data into every bank at once (whole-line write).
//  Revision    : 1.0 - initial release
// ============================================================================
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int WORDS = 4,
  parameter int DEPTH = 1024,
  localparam int OFF_W = $clog2(WORDS),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              we_all,
  input  logic [IDX_W-1:0]  widx,
  input  logic [OFF_W-1:0]  woff,
  input  logic [XLEN/8-1:0] wstrobe,
  input  logic [XLEN-1:0]   wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  input  logic [OFF_W-1:0]  roff,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0]  w_mask;
  logic [XLEN-1:0]  w_q [WORDS];
  logic [OFF_W-1:0] r_roff;

  assign w_mask = XLEN'(strobe_to_mask(C_MAX_STRB'(wstrobe)));

  for (genvar g = 0; g < WORDS; g++) begin : g_bank
    logic [XLEN-1:0] r_mem [DEPTH];
    logic [XLEN-1:0] r_q;
    logic            w_we;

    assign w_we = we && (we_all || (woff == OFF_W'(g)));

    // Byte-merged write and registered read of this word position.
    always_ff @(posedge clk) begin
      if (w_we) begin
        r_mem[widx] <= (r_mem[widx] & ~w_mask) | (wdata & w_mask);
      end
      if (re) begin
        r_q <= r_mem[ridx];
      end
    end

    assign w_q[g] = r_q;
  end

  // Remember which bank the pending read belongs to; holds while no read issues.
  always_ff @(posedge clk) begin
    if (re) begin
      r_roff <= roff;
    end
  end

  assign rdata = w_q[r_roff];

endmodule
`default_nettype wire

// File: rtl/line_mem_burst.sv
`default_nettype none
// ============================================================================
//  Module      : line_mem_burst
//  Description : Parametrised line memory with valid/ready request/response,
//                byte-strobed writes, range/alignment error beats and
//                critical-word-first wrapping burst reads of a whole line.
//                Optional macro LINE_MEM_CLEAR_EN adds a post-reset sweep that
//                zeroes one line per cycle before requests are accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_mem_burst
  import line_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd20000,
  parameter int          XLEN      = 32,
  parameter int          WORDS     = 4,
  parameter int          DEPTH     = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  line_mem_burst_if.slave bus
);

  localparam int          c_byte_w     = $clog2(XLEN / 8);
  localparam int          c_off_w      = $clog2(WORDS);
  localparam int          c_idx_w      = $clog2(DEPTH);
  localparam int          c_line_bytes = WORDS * XLEN / 8;
  localparam logic [32:0] c_size       = 33'(DEPTH) * 33'(c_line_bytes);
  localparam logic [31:0] c_align_mask = 32'(XLEN / 8 - 1);

  state_t               r_state;
  logic                 r_resp_valid;
  logic                 r_resp_last;
  logic                 r_resp_error;
  logic                 r_rd_sel;
  logic [c_off_w-1:0]   r_beat;
  logic [c_off_w-1:0]   r_off;
  logic [c_idx_w-1:0]   r_idx;
`ifdef LINE_MEM_CLEAR_EN
  logic [c_idx_w-1:0]   r_clr_idx;
`endif

  logic [31:0]          w_local;
  logic                 w_err;
  logic [c_off_w-1:0]   w_off;
  logic [c_idx_w-1:0]   w_idx;
  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_beat_done;
  logic                 w_burst_last;

  logic                 w_ram_we;
  logic                 w_ram_we_all;
  logic [c_idx_w-1:0]   w_ram_widx;
  logic [c_off_w-1:0]   w_ram_woff;
  logic [XLEN/8-1:0]    w_ram_wstrobe;
  logic [XLEN-1:0]      w_ram_wdata;
  logic                 w_ram_re;
  logic [c_idx_w-1:0]   w_ram_ridx;
  logic [c_off_w-1:0]   w_ram_roff;
  logic [XLEN-1:0]      w_ram_rdata;

  // Address decode; a below-base address wraps w_local high, so it also
  // trips the upper-bound compare.
  assign w_local = bus.req_adr - BASE_ADDR;
  assign w_err   = (bus.req_adr < BASE_ADDR)
                || ({1'b0, w_local} >= c_size)
                || ((bus.req_adr & c_align_mask) != 32'd0);
  assign w_off   = w_local[c_byte_w +: c_off_w];
  assign w_idx   = w_local[c_byte_w + c_off_w +: c_idx_w];

  // New work only from IDLE, and only when the output slot is free this cycle.
  assign w_req_ready  = (r_state == IDLE) && (!r_resp_valid || bus.resp_ready);
  assign w_accept     = bus.req_valid && w_req_ready;
  assign w_beat_done  = r_resp_valid && bus.resp_ready;
  assign w_burst_last = (r_beat == c_off_w'(WORDS - 1));

  // RAM port steering: request path, burst prefetch of the next wrapped word,
  // and the optional clear sweep.
  always_comb begin
    w_ram_we      = w_accept && bus.req_we && !w_err;
    w_ram_we_all  = 1'b0;
    w_ram_widx    = w_idx;
    w_ram_woff    = w_off;
    w_ram_wstrobe = bus.req_strobe;
    w_ram_wdata   = bus.req_data;
    w_ram_re      = (w_accept && !bus.req_we && !w_err)
                 || ((r_state == BURST) && w_beat_done && !w_burst_last);
    w_ram_ridx    = w_idx;
    w_ram_roff    = w_off;
    if (r_state == BURST) begin
      w_ram_ridx = r_idx;
      w_ram_roff = r_off + r_beat + c_off_w'(1);
    end
`ifdef LINE_MEM_CLEAR_EN
    if (r_state == CLEAR) begin
      w_ram_we      = rst_n;
      w_ram_we_all  = 1'b1;
      w_ram_widx    = r_clr_idx;
      w_ram_wstrobe = '1;
      w_ram_wdata   = '0;
    end
`endif
  end

  line_mem_array #(
    .XLEN  (XLEN),
    .WORDS (WORDS),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (w_ram_we),
    .we_all  (w_ram_we_all),
    .widx    (w_ram_widx),
    .woff    (w_ram_woff),
    .wstrobe (w_ram_wstrobe),
    .wdata   (w_ram_wdata),
    .re      (w_ram_re),
    .ridx    (w_ram_ridx),
    .roff    (w_ram_roff),
    .rdata   (w_ram_rdata)
  );

  // Control FSM and registered response flags; beat fields only move on a
  // handshake, so a stalled beat stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef LINE_MEM_CLEAR_EN
      r_state   <= CLEAR;
      r_clr_idx <= '0;
`else
      r_state   <= IDLE;
`endif
      r_resp_valid <= 1'b0;
      r_resp_last  <= 1'b0;
      r_resp_error <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_beat       <= '0;
      r_off        <= '0;
      r_idx        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_beat_done) begin
            r_resp_valid <= 1'b0;
          end
          if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_last  <= 1'b1;
            r_resp_error <= w_err;
            r_rd_sel     <= !w_err && !bus.req_we;
            if (!w_err && !bus.req_we && bus.req_burst) begin
              r_state     <= BURST;
              r_resp_last <= 1'b0;
              r_beat      <= '0;
              r_idx       <= w_idx;
              r_off       <= w_off;
            end
          end
        end
        BURST: begin
          if (w_beat_done) begin
            if (w_burst_last) begin
              r_state      <= IDLE;
              r_resp_valid <= 1'b0;
              r_resp_last  <= 1'b0;
              r_rd_sel     <= 1'b0;
              r_beat       <= '0;
            end else begin
              r_beat      <= r_beat + c_off_w'(1);
              r_resp_last <= (r_beat == c_off_w'(WORDS - 2));
            end
          end
        end
`ifdef LINE_MEM_CLEAR_EN
        CLEAR: begin
          r_clr_idx <= r_clr_idx + c_idx_w'(1);
          if (r_clr_idx == c_idx_w'(DEPTH - 1)) begin
            r_state <= IDLE;
          end
        end
`endif
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_rd_sel ? w_ram_rdata : '0;
  assign bus.resp_last  = r_resp_last;
  assign bus.resp_error = r_resp_error;

endmodule
`default_nettype wire

// File: tb/tb_line_mem_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_mem_burst
//  Description : Self-checking bench for line_mem_burst with a word-array
//                reference model of the memory contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_mem_burst;

  localparam logic [31:0] BASE = 32'd20000;
  localparam int NWORDS = 4096;
`ifdef LINE_MEM_CLEAR_EN
  localparam int READY_AFTER = 1024;
`else
  localparam int READY_AFTER = 1;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mdl [NWORDS];

  line_mem_burst_if #(.XLEN(32)) bus ();

  line_mem_burst #(
    .BASE_ADDR (BASE),
    .XLEN      (32),
    .WORDS     (4),
    .DEPTH     (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] wadr(input int wi);
    return BASE + 32'(wi * 4);
  endfunction

  // Drive one request and return just after the edge that accepts it.
  task automatic send(input logic we, input logic burst, input logic [31:0] adr,
                      input logic [31:0] data, input logic [3:0] strb, output int waited);
    int n;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_burst = burst;
    bus.req_adr = adr; bus.req_data = data; bus.req_strobe = strb;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    waited = n;
  endtask

  // Model update for a legal write.
  task automatic model_write(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] strb);
    int wi;
    wi = int'((adr - BASE) >> 2);
    mdl[wi] = merge(mdl[wi], data, strb);
  endtask

  task automatic model_reset();
`ifdef LINE_MEM_CLEAR_EN
    for (int i = 0; i < NWORDS; i++) mdl[i] = 32'd0;
`endif
  endtask

  task automatic test_reset();
    int k;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.resp_valid); end
    checks++; if (bus.resp_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.resp_last); end
    checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", bus.resp_error); end
    checks++; if (bus.resp_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.resp_data); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!bus.req_ready && k < 3000);
    checks++; if (k != READY_AFTER) begin errors++; $display("FAIL ready_after_reset: ready after %0d cycles want %0d", k, READY_AFTER); end
  endtask

  task automatic test_write_read();
    int w;
    send(1'b1, 1'b0, BASE + 4, 32'h11223344, 4'hF, w); model_write(BASE + 4, 32'h11223344, 4'hF);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd0 || bus.resp_last !== 1'b1 || bus.resp_error !== 1'b0) begin
      errors++; $display("FAIL wr_ack: v=%b d=%h l=%b e=%b want 1/0/1/0", bus.resp_valid, bus.resp_data, bus.resp_last, bus.resp_error); end
    send(1'b0, 1'b0, BASE + 4, 32'd0, 4'h0, w);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h11223344 || bus.resp_last !== 1'b1 || bus.resp_error !== 1'b0) begin
      errors++; $display("FAIL rd_full: v=%b d=%h l=%b e=%b want 1/11223344/1/0", bus.resp_valid, bus.resp_data, bus.resp_last, bus.resp_error); end
    send(1'b1, 1'b0, BASE + 4, 32'hAABBCCDD, 4'h5, w); model_write(BASE + 4, 32'hAABBCCDD, 4'h5);
    send(1'b0, 1'b0, BASE + 4, 32'd0, 4'h0, w);
    checks++; if (bus.resp_data !== 32'h11BB33DD) begin errors++; $display("FAIL rd_merge: got %h want 11bb33dd", bus.resp_data); end
    send(1'b1, 1'b0, BASE + 4, 32'hFFFFFFFF, 4'h0, w);
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_last !== 1'b1 || bus.resp_error !== 1'b0) begin
      errors++; $display("FAIL noop_ack: v=%b l=%b e=%b want 1/1/0", bus.resp_valid, bus.resp_last, bus.resp_error); end
    send(1'b0, 1'b0, BASE + 4, 32'd0, 4'h0, w);
    checks++; if (bus.resp_data !== 32'h11BB33DD) begin errors++; $display("FAIL rd_after_noop: got %h want 11bb33dd", bus.resp_data); end
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_beat_only: resp_valid=%b want 0", bus.resp_valid); end
  endtask

  task automatic test_burst();
    int w;
    logic [31:0] exp_beats [4];
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0, BASE + 32 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, w);
      model_write(BASE + 32 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
    end
    exp_beats[0] = 32'hA2; exp_beats[1] = 32'hA3; exp_beats[2] = 32'hA0; exp_beats[3] = 32'hA1;
    send(1'b0, 1'b1, BASE + 40, 32'd0, 4'h0, w);
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp_beats[k] || bus.resp_last !== (k == 3)) begin
        errors++; $display("FAIL burst_beat%0d: v=%b d=%h l=%b want 1/%h/%0d", k, bus.resp_valid, bus.resp_data, bus.resp_last, exp_beats[k], k == 3); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL burst_ready%0d: req_ready=%b want 0", k, bus.req_ready); end
      @(posedge clk); #1;
    end
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL burst_end: v=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_burst_stall();
    int w, line, s, k, cyc;
    logic p;
    for (int it = 0; it < 3; it++) begin
      line = 200 + int'($urandom_range(0, 99));
      for (int i = 0; i < 4; i++) begin
        send(1'b1, 1'b0, wadr(line * 4 + i), $urandom, 4'hF, w);
        model_write(wadr(line * 4 + i), bus.req_data, 4'hF);
      end
      s = int'($urandom_range(0, 3));
      send(1'b0, 1'b1, wadr(line * 4 + s), 32'd0, 4'h0, w);
      k = 0; cyc = 0;
      while (k < 4 && cyc < 60) begin
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== mdl[line * 4 + (s + k) % 4] || bus.resp_last !== (k == 3)) begin
          errors++; $display("FAIL stall_beat%0d: v=%b d=%h l=%b want 1/%h/%0d", k, bus.resp_valid, bus.resp_data, bus.resp_last, mdl[line * 4 + (s + k) % 4], k == 3); end
        if (it == 0) p = (cyc % 4 == 0) || (cyc % 4 == 3);
        else p = 1'($urandom_range(0, 1));
        bus.resp_ready = p;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: req_ready=%b want 0", bus.req_ready); end
        @(posedge clk); #1;
        if (p) k++;
        cyc++;
      end
      bus.resp_ready = 1'b1;
      checks++; if (k != 4 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL stall_done: beats=%0d v=%b want 4/0", k, bus.resp_valid); end
    end
  endtask

  task automatic test_errors();
    int w;
    logic [31:0] bad [4];
    bad[0] = BASE - 4; bad[1] = BASE + 16384; bad[2] = BASE + 2; bad[3] = BASE + 16384 + 8;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 1'(i % 2), bad[i], 32'd0, 4'h0, w);
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b1 || bus.resp_last !== 1'b1 || bus.resp_data !== 32'd0) begin
        errors++; $display("FAIL err_beat%0d: v=%b e=%b l=%b d=%h want 1/1/1/0", i, bus.resp_valid, bus.resp_error, bus.resp_last, bus.resp_data); end
      @(posedge clk); #1;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL err_single%0d: v=%b want 0", i, bus.resp_valid); end
    end
    send(1'b1, 1'b0, BASE, 32'h5A5A0001, 4'hF, w); model_write(BASE, 32'h5A5A0001, 4'hF);
    send(1'b1, 1'b0, BASE + 16384, 32'hDEADBEEF, 4'hF, w);
    send(1'b1, 1'b0, BASE + 6, 32'hDEADBEEF, 4'hF, w);
    checks++; if (bus.resp_error !== 1'b1) begin errors++; $display("FAIL err_write: e=%b want 1", bus.resp_error); end
    send(1'b0, 1'b0, BASE, 32'd0, 4'h0, w);
    checks++; if (bus.resp_data !== mdl[0]) begin errors++; $display("FAIL err_wr_alias: got %h want %h", bus.resp_data, mdl[0]); end
    send(1'b0, 1'b0, BASE + 4, 32'd0, 4'h0, w);
    checks++; if (bus.resp_data !== mdl[1]) begin errors++; $display("FAIL err_wr_misalign: got %h want %h", bus.resp_data, mdl[1]); end
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b0, wadr(400 + i), $urandom, 4'hF, w);
      model_write(wadr(400 + i), bus.req_data, 4'hF);
      if (i > 0) begin
        checks++; if (w != 0) begin errors++; $display("FAIL b2b_write%0d: waited %0d want 0", i, w); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 1'b0, wadr(400 + i), 32'd0, 4'h0, w);
      checks++; if (w != 0 || bus.resp_data !== mdl[400 + i] || bus.resp_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_read%0d: waited %0d d=%h v=%b want 0/%h/1", i, w, bus.resp_data, bus.resp_valid, mdl[400 + i]); end
    end
  endtask

  task automatic test_random();
    int w, op, wi, line, s;
    logic [31:0] d, a;
    logic [3:0] st;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 1'b0, wadr(2000 + i), $urandom, 4'hF, w);
      model_write(wadr(2000 + i), bus.req_data, 4'hF);
    end
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 3));
      wi = 2000 + int'($urandom_range(0, 15));
      if (op == 0) begin
        d = $urandom; st = 4'($urandom_range(0, 15));
        send(1'b1, 1'b0, wadr(wi), d, st, w); model_write(wadr(wi), d, st);
        checks++; if (bus.resp_data !== 32'd0 || bus.resp_last !== 1'b1 || bus.resp_error !== 1'b0) begin
          errors++; $display("FAIL rnd_wack: d=%h l=%b e=%b want 0/1/0", bus.resp_data, bus.resp_last, bus.resp_error); end
      end else if (op == 1) begin
        send(1'b0, 1'b0, wadr(wi), 32'd0, 4'h0, w);
        checks++; if (bus.resp_data !== mdl[wi] || bus.resp_last !== 1'b1 || bus.resp_error !== 1'b0) begin
          errors++; $display("FAIL rnd_read: d=%h l=%b e=%b want %h/1/0", bus.resp_data, bus.resp_last, bus.resp_error, mdl[wi]); end
      end else if (op == 2) begin
        line = wi / 4; s = wi % 4;
        send(1'b0, 1'b1, wadr(wi), 32'd0, 4'h0, w);
        for (int k = 0; k < 4; k++) begin
          checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== mdl[line * 4 + (s + k) % 4] || bus.resp_last !== (k == 3)) begin
            errors++; $display("FAIL rnd_burst%0d: v=%b d=%h l=%b want 1/%h/%0d", k, bus.resp_valid, bus.resp_data, bus.resp_last, mdl[line * 4 + (s + k) % 4], k == 3); end
          @(posedge clk); #1;
        end
      end else begin
        a = wadr(wi) + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) a = BASE + 32'd16384 + 32'($urandom_range(0, 255) * 4);
        send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, 4'hF, w);
        checks++; if (bus.resp_error !== 1'b1 || bus.resp_data !== 32'd0 || bus.resp_last !== 1'b1) begin
          errors++; $display("FAIL rnd_err: e=%b d=%h l=%b want 1/0/1", bus.resp_error, bus.resp_data, bus.resp_last); end
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int w, k;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0, wadr(2400 + i), $urandom, 4'hF, w);
      model_write(wadr(2400 + i), bus.req_data, 4'hF);
    end
    send(1'b0, 1'b1, wadr(2400), 32'd0, 4'h0, w);
    @(posedge clk); #1;
    checks++; if (bus.resp_data !== mdl[2401] || bus.resp_valid !== 1'b1) begin
      errors++; $display("FAIL mid_beat2: d=%h v=%b want %h/1", bus.resp_data, bus.resp_valid, mdl[2401]); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_last !== 1'b0) begin
      errors++; $display("FAIL mid_reset: v=%b l=%b want 0/0", bus.resp_valid, bus.resp_last); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    k = 0;
    do begin
      @(posedge clk); #1; k++;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_beats: v=%b want 0", bus.resp_valid); end
    end while (!bus.req_ready && k < 3000);
    checks++; if (k != READY_AFTER) begin errors++; $display("FAIL mid_ready_after: %0d want %0d", k, READY_AFTER); end
    send(1'b0, 1'b0, wadr(2402), 32'd0, 4'h0, w);
    checks++; if (bus.resp_data !== mdl[2402]) begin errors++; $display("FAIL mid_readback: got %h want %h", bus.resp_data, mdl[2402]); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_burst = 1'b0;
    bus.req_adr = 32'd0; bus.req_data = 32'd0; bus.req_strobe = 4'h0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < NWORDS; i++) mdl[i] = 32'd0;
    test_reset();
    test_write_read();
    test_burst();
    test_burst_stall();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_mem_burst.md
Name: line_mem_burst

Overview:
- Parametrised on-chip line memory; successor to the fixed 4x32-bit line store in dev/memory.
- Line geometry (word width, words per line, depth) and base address are configurable.
- Request/response are valid/ready handshaked. Writes merge by byte strobe. Out-of-range and misaligned requests are flagged.
- Adds critical-word-first wrapping burst reads of a whole line. Sits between a core load/store or fetch unit and the bus fabric.

Parameters:
- BASE_ADDR, 20000: first byte address decoded by the block.
- XLEN, 32: word width in bits; multiple of 8.
- WORDS, 4: words per line; power of 2, >= 2.
- DEPTH, 1024: number of lines; power of 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_burst  in  1  read a full line (ignored when req_we = 1).
- req_adr  in  32  byte address.
- req_data  in  XLEN  write data.
- req_strobe  in  XLEN/8  byte enables.
- resp_valid  out  1  response beat present.
- resp_ready  in  1  consumer accepts beat.
- resp_data  out  XLEN  read data; 0 for write acks and errors.
- resp_last  out  1  final beat of a response.
- resp_error  out  1  beat carries an error.

Behaviour:
- Decode:
  - local = req_adr - BASE_ADDR.
  - word offset = local[log2(WORDS*XLEN/8)-1 : log2(XLEN/8)].
  - line index = next log2(DEPTH) bits.
- Error condition, evaluated at acceptance:
  - req_adr < BASE_ADDR, or
  - req_adr >= BASE_ADDR + DEPTH*WORDS*XLEN/8, or
  - req_adr not XLEN/8-aligned.
- An erroring request produces exactly one beat: resp_error = 1, resp_last = 1, resp_data = 0. No memory write occurs, even for a burst.
- Handshake and backpressure:
  - Accept on req_valid && req_ready.
  - req_ready = (state == IDLE) && (!resp_valid || resp_ready).
  - Each beat completes on resp_valid && resp_ready.
  - While resp_valid && !resp_ready, resp_data/resp_last/resp_error hold stable.
- FSM states IDLE, BURST (plus CLEAR with the option).
- Single read: accepted at cycle N, beat at cycle N+1 with resp_last = 1. Stays in IDLE, so back-to-back reads sustain 1 per cycle when resp_ready = 1.
- Write:
  - Bytes with strobe = 1 are replaced; bytes with strobe = 0 keep their old value (not zeroed).
  - Ack beat at N+1: resp_data = 0, resp_last = 1.
  - strobe = 0 is a legal no-op write and is still acked.
- Burst read (req_burst = 1, no error):
  - IDLE -> BURST.
  - Emits WORDS beats starting at the addressed word offset, wrapping modulo WORDS within the line (critical word first).
  - The beat counter advances only on handshake. resp_last is set on beat WORDS-1.
  - BURST -> IDLE on the last handshake.
- Read-during-write: impossible by construction, since only one request is in flight.
- Reset:
  - rst_n = 0 at a clock edge clears state to IDLE, resp_valid/resp_last/resp_error to 0, resp_data to 0, and the beat counter.
  - Reset during BURST abandons the burst; no further beats.
  - Memory contents are not reset unless the option is enabled.

Optional Feature:
- Macro LINE_MEM_CLEAR_EN.
- When defined: on reset deassertion, enters CLEAR and writes zero to one line per cycle, index 0..DEPTH-1. req_ready = 0 throughout. Goes to IDLE after DEPTH cycles. Reset asserted mid-clear restarts the sweep at 0.
- When undefined: no CLEAR state, memory is uninitialised, and req_ready can be 1 on the first cycle after reset.

Decomposition:
- Package line_mem_pkg holds:
  - state enum (IDLE, BURST, CLEAR);
  - localparams for byte/offset/index widths;
  - function strobe_to_mask(strobe) returning the XLEN bit mask.
- One natural sub-module: line_mem_array, the storage with a per-word byte-enabled write port and a synchronous word read port. Keeps the RAM inferable.

Test Plan:
- Write 0x11223344, strobe 0xF, to BASE_ADDR+4; read it back -> single beat 0x11223344, resp_last = 1, resp_error = 0, at +1 cycle.
- Write 0xAABBCCDD, strobe 0x5, over that word; read back -> 0x11BB33DD (unstrobed bytes preserved).
- Preload line 2 with words 0xA0..0xA3; burst read at BASE_ADDR+32+8 -> 4 beats 0xA2, 0xA3, 0xA0, 0xA1, resp_last only on the 4th.
- Burst with resp_ready toggling 1,0,0,1,...: beats hold stable while stalled, no beat is lost or duplicated, and req_ready = 0 until the last handshake.
- Read BASE_ADDR-4, BASE_ADDR+16384, and BASE_ADDR+2 -> each returns 1 beat with resp_error = 1 and resp_data = 0. An errored write leaves memory unchanged.
- Assert rst_n = 0 during beat 2 of a burst -> next cycle resp_valid = 0 and state is IDLE. With LINE_MEM_CLEAR_EN defined, req_ready stays 0 for 1024 cycles, then any read returns 0.
